// File: rtl/trap_ctrl.sv
// Trap/exception controller: captures EPC and cause, redirects to per-cause vectors,
// tail-chains requests that arrive during a handler, and latches a double fault.
module trap_ctrl #(
  parameter int          XLEN       = 64,
  parameter int          NCAUSE     = 4,
  parameter logic [63:0] VEC_BASE   = 64'h0000_0000_0000_0100,
  parameter logic [63:0] VEC_STRIDE = 64'd16,
  parameter int          CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NCAUSE-1:0] cause_req,
  input  logic [XLEN-1:0]   pc_cur,
  input  logic              mret,
  input  logic              redir_ack,
  output logic              redir_valid,
  output logic [XLEN-1:0]   redir_pc,
  output logic [XLEN-1:0]   epc,
  output logic [XLEN-1:0]   cause,
  output logic              in_handler,
  output logic              fault,
  output logic [CNT_W-1:0]  trap_count
);

  localparam int CW = $clog2(NCAUSE);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER, S_HANDLER, S_RETURN, S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [XLEN-1:0]    cause_q, cause_d;
  logic [NCAUSE-1:0]  pending_q, pending_d;
  logic [NCAUSE-1:0]  req_prev_q, req_prev_d;
  logic [CNT_W-1:0]   trap_count_q, trap_count_d;

  logic [NCAUSE-1:0]  act_mask;
  logic [NCAUSE-1:0]  merged;
  logic [NCAUSE-1:0]  idle_all;
  logic [CW-1:0]      win_idle;
  logic [CW-1:0]      win_chain;
  logic [CNT_W-1:0]   cnt_inc;
  logic               act_rise;

  // Lowest set index wins; scanning downward leaves the smallest index last.
  function automatic logic [CW-1:0] lowest(input logic [NCAUSE-1:0] v);
    lowest = '0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (v[i]) lowest = CW'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    act_mask  = NCAUSE'(1) << cause_q[CW-1:0];
    merged    = pending_q | (cause_req & ~act_mask);
    idle_all  = pending_q | cause_req;
    win_idle  = lowest(idle_all);
    win_chain = lowest(merged);
    cnt_inc   = sat_inc(trap_count_q);
    act_rise  = |(cause_req & ~req_prev_q & act_mask);
  end

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    pending_d    = pending_q;
    trap_count_d = trap_count_q;
    req_prev_d   = cause_req;
    case (state_q)
      S_IDLE: begin
        if (idle_all != '0) begin
          epc_d        = pc_cur - XLEN'(4);
          cause_d      = XLEN'(win_idle);
          pending_d    = idle_all & ~(NCAUSE'(1) << win_idle);
          trap_count_d = cnt_inc;
          state_d      = S_ENTER;
        end
      end
      S_ENTER: begin
        pending_d = merged;
        if (redir_ack) state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (act_rise) begin
          state_d = S_FAULT;
        end else if (mret && merged != '0) begin
          // Tail-chain: new requests are merged before the winner is chosen.
          cause_d      = XLEN'(win_chain);
          pending_d    = merged & ~(NCAUSE'(1) << win_chain);
          trap_count_d = cnt_inc;
          state_d      = S_ENTER;
        end else begin
          pending_d = merged;
          if (mret) state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        pending_d = merged;
        if (redir_ack) state_d = S_IDLE;
      end
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      pending_q    <= '0;
      req_prev_q   <= '0;
      trap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      pending_q    <= pending_d;
      req_prev_q   <= req_prev_d;
      trap_count_q <= trap_count_d;
    end
  end

  always_comb begin
    redir_valid = (state_q == S_ENTER) || (state_q == S_RETURN);
    redir_pc    = epc_q;
    if (state_q == S_ENTER) redir_pc = VEC_BASE[XLEN-1:0] + cause_q * VEC_STRIDE[XLEN-1:0];
    in_handler  = (state_q == S_HANDLER);
    fault       = (state_q == S_FAULT);
    epc         = epc_q;
    cause       = cause_q;
    trap_count  = trap_count_q;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scenario bench for trap_ctrl: redirect targets are scored from a queue of expected PCs.
module tb_trap_ctrl;

  logic        Clk;
  logic        Reset;
  logic [3:0]  cause_req;
  logic [63:0] pc_cur;
  logic        mret;
  logic        redir_ack;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic [63:0] epc;
  logic [63:0] cause;
  logic        in_handler;
  logic        fault;
  logic [15:0] trap_count;

  logic        redir_valid2;
  logic [63:0] redir_pc2;
  logic [63:0] epc2;
  logic [63:0] cause2;
  logic        in_handler2;
  logic        fault2;
  logic [1:0]  trap_count2;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;

  trap_ctrl dut (
    .Clk(Clk), .Reset(Reset), .cause_req(cause_req), .pc_cur(pc_cur), .mret(mret),
    .redir_ack(redir_ack), .redir_valid(redir_valid), .redir_pc(redir_pc), .epc(epc),
    .cause(cause), .in_handler(in_handler), .fault(fault), .trap_count(trap_count)
  );

  trap_ctrl #(.CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .cause_req(cause_req), .pc_cur(pc_cur), .mret(mret),
    .redir_ack(redir_ack), .redir_valid(redir_valid2), .redir_pc(redir_pc2), .epc(epc2),
    .cause(cause2), .in_handler(in_handler2), .fault(fault2), .trap_count(trap_count2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Every accepted redirect must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && redir_valid && redir_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected redir_pc got %h exp none", redir_pc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (redir_pc !== sb_exp) begin
          errors++;
          $display("FAIL sb_redir_pc got %h exp %h", redir_pc, sb_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; cause_req = '0; mret = 1'b0; redir_ack = 1'b0; pc_cur = '0;
    step();
    Reset = 1'b0;
  endtask

  task automatic do_ack();
    int n;
    n = 0;
    while (!redir_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!redir_valid) begin
      errors++;
      $display("FAIL ack_timeout redir_valid got 0 exp 1");
    end
    redir_ack = 1'b1;
    step();
    redir_ack = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1;
    step();
    mret = 1'b0;
  endtask

  task automatic raise(input logic [3:0] req, input logic [63:0] pc);
    cause_req = req; pc_cur = pc;
    step();
    cause_req = '0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", redir_valid); end
    checks++; if (epc !== 64'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", epc); end
    checks++; if (cause !== 64'h0) begin errors++; $display("FAIL rst_cause got %h exp 0", cause); end
    checks++; if (trap_count !== 16'h0) begin errors++; $display("FAIL rst_count got %0d exp 0", trap_count); end
    checks++; if (in_handler !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", in_handler, fault); end
    checks++; if (redir_pc !== 64'h0) begin errors++; $display("FAIL rst_redir_pc got %h exp 0", redir_pc); end
    redir_ack = 1'b1;
    do_mret();
    redir_ack = 1'b0;
    checks++; if (redir_valid !== 1'b0 || in_handler !== 1'b0) begin errors++; $display("FAIL idle_ignore got %b%b exp 00", redir_valid, in_handler); end
  endtask

  task automatic test_single();
    do_reset();
    exp_q.push_back(64'h120);
    raise(4'b0100, 64'h208);
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", redir_valid); end
    checks++; if (redir_pc !== 64'h120) begin errors++; $display("FAIL single_vec got %h exp 120", redir_pc); end
    checks++; if (epc !== 64'h204) begin errors++; $display("FAIL single_epc got %h exp 204", epc); end
    checks++; if (cause !== 64'd2) begin errors++; $display("FAIL single_cause got %0d exp 2", cause); end
    checks++; if (trap_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", trap_count); end
    do_ack();
    checks++; if (in_handler !== 1'b1 || redir_valid !== 1'b0) begin errors++; $display("FAIL single_handler got %b%b exp 10", in_handler, redir_valid); end
    exp_q.push_back(64'h204);
    do_mret();
    checks++; if (redir_valid !== 1'b1 || redir_pc !== 64'h204) begin errors++; $display("FAIL single_return got %b %h exp 1 204", redir_valid, redir_pc); end
    do_ack();
    checks++; if (redir_valid !== 1'b0 || in_handler !== 1'b0) begin errors++; $display("FAIL single_idle got %b%b exp 00", redir_valid, in_handler); end
  endtask

  task automatic test_priority();
    do_reset();
    exp_q.push_back(64'h110);
    raise(4'b1010, 64'h300);
    checks++; if (cause !== 64'd1 || redir_pc !== 64'h110) begin errors++; $display("FAIL prio_first got %0d %h exp 1 110", cause, redir_pc); end
    do_ack();
    exp_q.push_back(64'h130);
    do_mret();
    checks++; if (redir_valid !== 1'b1 || cause !== 64'd3) begin errors++; $display("FAIL prio_chain got %b %0d exp 1 3", redir_valid, cause); end
    checks++; if (redir_pc !== 64'h130) begin errors++; $display("FAIL prio_vec got %h exp 130", redir_pc); end
    checks++; if (epc !== 64'h2FC) begin errors++; $display("FAIL prio_epc got %h exp 2fc", epc); end
    checks++; if (trap_count !== 16'd2) begin errors++; $display("FAIL prio_count got %0d exp 2", trap_count); end
    do_ack();
    exp_q.push_back(64'h2FC);
    do_mret();
    do_ack();
    checks++; if (redir_valid !== 1'b0 || in_handler !== 1'b0) begin errors++; $display("FAIL prio_idle got %b%b exp 00", redir_valid, in_handler); end
  endtask

  task automatic test_merge();
    do_reset();
    exp_q.push_back(64'h100);
    raise(4'b0001, 64'h700);
    do_ack();
    exp_q.push_back(64'h130);
    cause_req = 4'b1000; mret = 1'b1;
    step();
    cause_req = '0; mret = 1'b0;
    checks++; if (cause !== 64'd3 || redir_pc !== 64'h130) begin errors++; $display("FAIL merge_chain got %0d %h exp 3 130", cause, redir_pc); end
    do_ack();
    exp_q.push_back(64'h6FC);
    do_mret();
    do_ack();
  endtask

  task automatic test_double_fault();
    do_reset();
    exp_q.push_back(64'h100);
    raise(4'b0001, 64'h400);
    do_ack();
    raise(4'b0001, 64'h400);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL df_fault got %b exp 1", fault); end
    checks++; if (redir_valid !== 1'b0 || in_handler !== 1'b0) begin errors++; $display("FAIL df_outputs got %b%b exp 00", redir_valid, in_handler); end
    redir_ack = 1'b1;
    do_mret();
    step();
    redir_ack = 1'b0;
    checks++; if (redir_valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL df_sticky got %b%b exp 01", redir_valid, fault); end
    do_reset();
    step();
    checks++; if (fault !== 1'b0 || trap_count !== 16'd0) begin errors++; $display("FAIL df_reset got %b %0d exp 0 0", fault, trap_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    exp_q.push_back(64'h100);
    raise(4'b0001, 64'h0);
    checks++; if (epc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_epc got %h exp fffffffffffffffc", epc); end
    do_ack();
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    do_mret();
    do_ack();
  endtask

  task automatic test_saturation();
    logic [1:0] exp2;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(64'h100);
      raise(4'b0001, 64'h1000);
      exp2 = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++; if (trap_count2 !== exp2) begin errors++; $display("FAIL sat_count%0d got %0d exp %0d", i, trap_count2, exp2); end
      do_ack();
      exp_q.push_back(64'hFFC);
      do_mret();
      do_ack();
    end
    checks++; if (trap_count !== 16'd5) begin errors++; $display("FAIL sat_wide_count got %0d exp 5", trap_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    raise(4'b0010, 64'h500);
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b exp 1", redir_valid); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (redir_valid !== 1'b0 || epc !== 64'h0 || cause !== 64'h0) begin errors++; $display("FAIL mid_reset got %b %h %h exp 0 0 0", redir_valid, epc, cause); end
    checks++; if (trap_count !== 16'd0 || in_handler !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl got %0d %b %b exp 0 0 0", trap_count, in_handler, fault); end
    exp_q.push_back(64'h120);
    raise(4'b0100, 64'h208);
    checks++; if (redir_valid !== 1'b1 || cause !== 64'd2 || trap_count !== 16'd1) begin errors++; $display("FAIL mid_after got %b %0d %0d exp 1 2 1", redir_valid, cause, trap_count); end
    do_ack();
    exp_q.push_back(64'h204);
    do_mret();
    do_ack();
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.push_back(64'h100);
    raise(4'b0001, 64'h600);
    for (int i = 0; i < 5; i++) begin
      checks++; if (redir_valid !== 1'b1 || redir_pc !== 64'h100) begin errors++; $display("FAIL bp_hold%0d got %b %h exp 1 100", i, redir_valid, redir_pc); end
      cause_req = (i == 2) ? 4'b0100 : 4'b0000;
      step();
    end
    cause_req = '0;
    do_ack();
    exp_q.push_back(64'h120);
    do_mret();
    checks++; if (cause !== 64'd2 || trap_count !== 16'd2 || epc !== 64'h5FC) begin errors++; $display("FAIL bp_chain got %0d %0d %h exp 2 2 5fc", cause, trap_count, epc); end
    do_ack();
    exp_q.push_back(64'h5FC);
    do_mret();
    do_ack();
    checks++; if (redir_valid !== 1'b0 || in_handler !== 1'b0) begin errors++; $display("FAIL bp_idle got %b%b exp 00", redir_valid, in_handler); end
  endtask

  initial begin
    Reset = 1'b1; cause_req = '0; pc_cur = '0; mret = 1'b0; redir_ack = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_merge();
    test_double_fault();
    test_wrap();
    test_saturation();
    test_reset_mid();
    test_backpressure();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Parametrised trap/exception controller for the multicycle RISC-V core. It collects up to NCAUSE exception requests and captures the faulting PC into EPC and the encoded cause into the cause register. It issues a redirect to a per-cause vector address and, on return, a redirect back to EPC. It adds tail-chaining of requests that arrive while a handler runs, double-fault detection and a trap counter. It sits beside the control unit and drives the PC-source path in place of fixed EPC/cause registers.

## Interface
- XLEN, 64, datapath width of PC, EPC, cause and vector values
- NCAUSE, 4, number of exception request lines (2..16)
- VEC_BASE, 64'h0000_0000_0000_0100, vector base address (truncated to XLEN)
- VEC_STRIDE, 64'd16, byte distance between consecutive cause vectors
- CNT_W, 16, width of the saturating trap counter

- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- cause_req  in  NCAUSE  exception requests, level; bit i = cause code i
- pc_cur  in  XLEN  current PC register value (already advanced by 4)
- mret  in  1  handler-return strobe from control unit, one cycle
- redir_ack  in  1  control unit has loaded redir_pc into PC this cycle
- redir_valid  out  1  redirect request pending
- redir_pc  out  XLEN  redirect target (vector or EPC)
- epc  out  XLEN  exception PC register
- cause  out  XLEN  cause register, code zero-extended
- in_handler  out  1  high in HANDLER state
- fault  out  1  sticky double-fault flag; core must halt
- trap_count  out  CNT_W  number of trap entries, saturating

## Operation
- States: IDLE, ENTER, HANDLER, RETURN, FAULT.
- Priority: the lowest set bit index wins. Code = that index.
- IDLE: if cause_req != 0, load epc <= pc_cur - 4 (mod 2^XLEN) and cause <= code. Set pending <= cause_req with the winning bit cleared. Increment trap_count. Go to ENTER.
- ENTER: redir_valid=1, redir_pc = VEC_BASE + cause*VEC_STRIDE (mod 2^XLEN). On redir_ack, go to HANDLER.
- HANDLER: in_handler=1.
  - If a newly asserted request bit equals the active cause, set fault and go to FAULT. This takes precedence over mret.
  - Otherwise, on mret with pending != 0: tail-chain. Select the lowest pending bit, update cause, clear that bit, increment trap_count, go to ENTER. epc is unchanged.
  - On mret with pending == 0, go to RETURN.
- RETURN: redir_valid=1, redir_pc = epc. On redir_ack, go to IDLE.
- FAULT: terminal. All redirects are off and fault=1. Only Reset leaves this state.
- Pending register (NCAUSE bits):
  - In ENTER, HANDLER and RETURN, it ORs in every cause_req bit other than the active cause.
  - Requests seen in RETURN are taken after the return completes: IDLE takes pending|cause_req on the next cycle, with epc captured from pc_cur at that time.
- A "new" assertion of the active cause means a rising edge relative to the previous cycle's sampled cause_req.
- trap_count holds at 2^CNT_W-1 and never wraps.
- When redir_valid=0, redir_pc = epc. This keeps it stable; its value is don't-care for consumers.

## Timing
- Reset values: state IDLE, epc 0, cause 0, pending 0, trap_count 0, fault 0, redir_valid 0, in_handler 0.
- Latency from request to redir_valid: 1 cycle. cause_req sampled in IDLE at edge n gives redir_valid=1 after edge n.
- redir_valid stays high, with redir_pc stable, until the cycle redir_ack is sampled high. It drops after that edge.
- redir_ack while redir_valid=0 is ignored.
- mret outside HANDLER is ignored.
- Simultaneous cause_req (not the active cause) and mret in HANDLER: the request is merged into pending first, then the tail-chain is taken in the same cycle.
- Reset asserted in any state, including mid-redirect or FAULT, returns everything to reset values on the next edge. Reset overrides all inputs.

## Test plan
- Single trap, XLEN=64, NCAUSE=4, defaults:
  - Stimulus: cause_req=4'b0100, pc_cur=0x208.
  - Required: next cycle redir_valid=1, redir_pc=0x120, epc=0x204, cause=2, trap_count=1.
  - Then: ack gives in_handler=1; mret then ack gives redir_pc=0x204, then IDLE.
- Priority: cause_req=4'b1010 in IDLE -> cause=1, redir_pc=0x110. On mret, tail-chain to cause=3, redir_pc=0x130, epc unchanged, trap_count=2. No RETURN in between.
- Double fault: in HANDLER with cause=0, cause_req bit0 rises -> fault=1 the next cycle. redir_valid stays 0 even with a later mret. Reset clears fault.
- Wrap and saturation:
  - pc_cur=0 gives epc=0xFFFF_FFFF_FFFF_FFFC.
  - With CNT_W=2, five trap entries leave trap_count=3.
- Reset mid-ENTER with redir_valid=1 -> next cycle all outputs at reset values. A request presented the following cycle is handled normally.
- Backpressure: hold redir_ack=0 for 5 cycles in ENTER -> redir_valid and redir_pc are constant. A cause_req for another cause during the stall is held in pending and taken on mret.
